// File: rtl/turn_scheduler.sv
// Battleship game-flow controller: placement, alternating player/computer shots,
// guess-mask accumulation, hit counting and win detection.
module turn_scheduler #(
  parameter int CELLS    = 28,
  parameter int IDX_W    = 5,
  parameter int WIN_HITS = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             place_done,
  input  logic [IDX_W-1:0] p_idx,
  input  logic [CELLS-1:0] pships,
  input  logic [CELLS-1:0] cships,
  input  logic             c_ack,
  input  logic [IDX_W-1:0] c_idx,
  output logic             phase,
  output logic             turn,
  output logic             c_req,
  output logic [CELLS-1:0] pguess,
  output logic [CELLS-1:0] cguess,
  output logic [CNT_W-1:0] p_hits,
  output logic [CNT_W-1:0] c_hits,
  output logic             hit,
  output logic             bad_shot,
  output logic             finish,
  output logic             winner
);

  typedef enum logic [2:0] {
    S_PLACE,
    S_P_TURN,
    S_P_EVAL,
    S_C_REQ,
    S_C_BACKOFF,
    S_C_EVAL,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN_HITS);
  localparam logic [CELLS-1:0] CELL_ONE = {{(CELLS-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel_q;
  logic [CELLS-1:0] r_pguess;
  logic [CELLS-1:0] r_cguess;
  logic [CNT_W-1:0] r_p_hits;
  logic [CNT_W-1:0] r_c_hits;
  logic             r_shot_hit;
  logic             r_hit;
  logic             r_bad_shot;
  logic             r_winner;

  logic             w_sel_rise;
  logic [CELLS-1:0] w_p_onehot;
  logic [CELLS-1:0] w_c_onehot;
  logic             w_p_ok;
  logic             w_c_ok;
  logic [CNT_W-1:0] w_p_hits_nxt;
  logic [CNT_W-1:0] w_c_hits_nxt;

  assign w_sel_rise = sel & ~r_sel_q;

  // A shift past the top cell yields an all-zero one-hot, but the explicit
  // range check keeps the intent readable.
  assign w_p_onehot = CELL_ONE << p_idx;
  assign w_c_onehot = CELL_ONE << c_idx;
  assign w_p_ok     = ({{(32-IDX_W){1'b0}}, p_idx} < CELLS) && ~|(r_pguess & w_p_onehot);
  assign w_c_ok     = ({{(32-IDX_W){1'b0}}, c_idx} < CELLS) && ~|(r_cguess & w_c_onehot);

  assign w_p_hits_nxt = r_p_hits + {{(CNT_W-1){1'b0}}, r_shot_hit};
  assign w_c_hits_nxt = r_c_hits + {{(CNT_W-1){1'b0}}, r_shot_hit};

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_PLACE:     if (w_sel_rise && place_done) w_state_nxt = S_P_TURN;
      S_P_TURN:    if (w_sel_rise && w_p_ok)     w_state_nxt = S_P_EVAL;
      S_P_EVAL:    w_state_nxt = (w_p_hits_nxt == WIN_CNT) ? S_DONE : S_C_REQ;
      S_C_REQ:     if (c_ack) w_state_nxt = w_c_ok ? S_C_EVAL : S_C_BACKOFF;
      S_C_BACKOFF: w_state_nxt = S_C_REQ;
      S_C_EVAL:    w_state_nxt = (w_c_hits_nxt == WIN_CNT) ? S_DONE : S_P_TURN;
      S_DONE:      if (w_sel_rise) w_state_nxt = S_PLACE;
      default:     w_state_nxt = S_PLACE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLACE;
      r_sel_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel_q <= sel;
    end
  end

  // NOTE: the guess masks are plain flops, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pguess   <= '0;
      r_cguess   <= '0;
      r_p_hits   <= '0;
      r_c_hits   <= '0;
      r_shot_hit <= 1'b0;
      r_hit      <= 1'b0;
      r_bad_shot <= 1'b0;
      r_winner   <= 1'b0;
    end else begin
      r_hit      <= 1'b0;
      r_bad_shot <= 1'b0;
      unique case (r_state)
        S_P_TURN: begin
          if (w_sel_rise) begin
            if (w_p_ok) begin
              r_pguess   <= r_pguess | w_p_onehot;
              r_shot_hit <= |(cships & w_p_onehot);
            end else begin
              r_bad_shot <= 1'b1;
            end
          end
        end
        S_P_EVAL: begin
          r_hit    <= r_shot_hit;
          r_p_hits <= w_p_hits_nxt;
          if (w_p_hits_nxt == WIN_CNT) r_winner <= 1'b0;
        end
        S_C_REQ: begin
          if (c_ack && w_c_ok) begin
            r_cguess   <= r_cguess | w_c_onehot;
            r_shot_hit <= |(pships & w_c_onehot);
          end
        end
        S_C_EVAL: begin
          r_hit    <= r_shot_hit;
          r_c_hits <= w_c_hits_nxt;
          if (w_c_hits_nxt == WIN_CNT) r_winner <= 1'b1;
        end
        S_DONE: begin
          // Leaving DONE starts a fresh game, so all game state clears on the same edge.
          if (w_sel_rise) begin
            r_pguess   <= '0;
            r_cguess   <= '0;
            r_p_hits   <= '0;
            r_c_hits   <= '0;
            r_shot_hit <= 1'b0;
            r_winner   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase    = (r_state != S_PLACE);
  assign turn     = (r_state == S_C_REQ) || (r_state == S_C_BACKOFF) ||
                    (r_state == S_C_EVAL) || ((r_state == S_DONE) && r_winner);
  assign c_req    = (r_state == S_C_REQ);
  assign finish   = (r_state == S_DONE);
  assign winner   = r_winner;
  assign hit      = r_hit;
  assign bad_shot = r_bad_shot;
  assign pguess   = r_pguess;
  assign cguess   = r_cguess;
  assign p_hits   = r_p_hits;
  assign c_hits   = r_c_hits;

endmodule
